// File: rtl/jtag_tap_pkg.sv
// ----------------------------------------------------------------------------
// jtag_tap_pkg
// Shared definitions for the JTAG TAP controller:
//   tap_state_t       - 4-bit TAP state with the IEEE 1149.1 encodings, so the
//                       raw register value matches what debug tools expect.
//   TAP_TLR_TMS_ONES  - number of consecutive TMS=1 rising edges that always
//                       land the FSM in Test-Logic-Reset.
// ----------------------------------------------------------------------------
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_t;

    localparam int TAP_TLR_TMS_ONES = 5;

endpackage

// File: rtl/jtag_tap_tdo_mux.sv
// ----------------------------------------------------------------------------
// jtag_tap_tdo_mux
// Falling-edge retiming of the serial TDO path. Selects the IR or DR serial
// output while the TAP is in a shift state and drives the output enable.
// Outside the shift states tdo keeps its last value and tdo_oe drops.
// Ports:
//   tck       in  test clock (register updates on the falling edge)
//   trstn     in  asynchronous active-low clear
//   shift_ir  in  TAP is in Shift-IR
//   shift_dr  in  TAP is in Shift-DR
//   insn_tdo  in  serial out of the instruction register
//   dr_tdo    in  serial out of the selected data register
//   tdo       out serial data to the pin
//   tdo_oe    out TDO output enable
// ----------------------------------------------------------------------------
module jtag_tap_tdo_mux (
    input  logic tck,
    input  logic trstn,
    input  logic shift_ir,
    input  logic shift_dr,
    input  logic insn_tdo,
    input  logic dr_tdo,
    output logic tdo,
    output logic tdo_oe
);

    logic tdo_reg;
    logic tdo_oe_reg;

    // Updating on the falling edge gives the capturing device a full half
    // cycle of setup before the next rising edge.
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo_reg    <= 1'b0;
            tdo_oe_reg <= 1'b0;
        end else begin
            tdo_oe_reg <= shift_ir | shift_dr;
            if (shift_ir) begin
                tdo_reg <= insn_tdo;
            end else if (shift_dr) begin
                tdo_reg <= dr_tdo;
            end
        end
    end

    assign tdo    = tdo_reg;
    assign tdo_oe = tdo_oe_reg;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// ----------------------------------------------------------------------------
// jtag_tap_ctrl
// IEEE 1149.1 TAP controller: 16-state TMS-driven FSM, one-hot decodes of the
// states the IR/DR blocks care about, and the falling-edge TDO mux.
// Optional build macro: JTAG_TAP_STATE_OUT_EN adds output tap_state[3:0]
// carrying the raw encoded state register (reset value 4'hF).
// Ports:
//   tck, trstn                  test clock, asynchronous active-low reset
//   tms                         test mode select (sampled on rising tck)
//   insn_tdo, dr_tdo            serial outputs of the IR / selected DR
//   tdo, tdo_oe                 pin data and output enable (falling-edge)
//   state_test_logic_reset, state_run_test_idle
//   state_capture_dr, state_shift_dr, state_update_dr, state_pause_dr
//   state_capture_ir, state_shift_ir, state_update_ir, state_pause_ir
//                               state decodes, high for the whole TCK cycle
//   tap_state                   (JTAG_TAP_STATE_OUT_EN only) raw state
// ----------------------------------------------------------------------------
module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter int TLR_TMS_ONES = TAP_TLR_TMS_ONES
) (
    input  logic       tck,
    input  logic       trstn,
    input  logic       tms,
    input  logic       insn_tdo,
    input  logic       dr_tdo,
    output logic       tdo,
    output logic       tdo_oe,
    output logic       state_test_logic_reset,
    output logic       state_run_test_idle,
    output logic       state_capture_dr,
    output logic       state_shift_dr,
    output logic       state_update_dr,
    output logic       state_pause_dr,
    output logic       state_capture_ir,
    output logic       state_shift_ir,
    output logic       state_update_ir,
    output logic       state_pause_ir
`ifdef JTAG_TAP_STATE_OUT_EN
    ,
    output logic [3:0] tap_state
`endif
);

    tap_state_t state_reg;
    tap_state_t state_next;
    logic       released_reg;

    // released_reg is low for the first rising edge after trstn goes high,
    // so a release that coincides with an edge never lets that edge move the
    // FSM out of Test-Logic-Reset; the first transition is on the next edge.
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            state_reg    <= TAP_TLR;
            released_reg <= 1'b0;
        end else begin
            released_reg <= 1'b1;
            if (released_reg) begin
                state_reg <= state_next;
            end
        end
    end

    always_comb begin
        state_next = TAP_TLR;
        case (state_reg)
            TAP_TLR:      state_next = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_next = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_next = tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_SH_DR:    state_next = tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_EX1_DR:   state_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_next = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_next = tms ? TAP_UPD_DR   : TAP_SH_DR;
            TAP_UPD_DR:   state_next = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_next = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_next = tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_SH_IR:    state_next = tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_EX1_IR:   state_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_next = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_next = tms ? TAP_UPD_IR   : TAP_SH_IR;
            TAP_UPD_IR:   state_next = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      state_next = TAP_TLR;
        endcase
    end

    // One-hot decodes, purely combinational from the state register.
    localparam int N_DEC = 10;
    localparam tap_state_t DEC_STATE [N_DEC] = '{
        TAP_TLR, TAP_RTI,
        TAP_CAP_DR, TAP_SH_DR, TAP_UPD_DR, TAP_PAUSE_DR,
        TAP_CAP_IR, TAP_SH_IR, TAP_UPD_IR, TAP_PAUSE_IR
    };

    logic [N_DEC-1:0] dec_vec;

    generate
        for (genvar gi = 0; gi < N_DEC; gi++) begin : g_dec
            assign dec_vec[gi] = (state_reg == DEC_STATE[gi]);
        end
    endgenerate

    assign state_test_logic_reset = dec_vec[0];
    assign state_run_test_idle    = dec_vec[1];
    assign state_capture_dr       = dec_vec[2];
    assign state_shift_dr         = dec_vec[3];
    assign state_update_dr        = dec_vec[4];
    assign state_pause_dr         = dec_vec[5];
    assign state_capture_ir       = dec_vec[6];
    assign state_shift_ir         = dec_vec[7];
    assign state_update_ir        = dec_vec[8];
    assign state_pause_ir         = dec_vec[9];

`ifdef JTAG_TAP_STATE_OUT_EN
    assign tap_state = state_reg;
`endif

    jtag_tap_tdo_mux u_tdo_mux (
        .tck      (tck),
        .trstn    (trstn),
        .shift_ir (dec_vec[7]),
        .shift_dr (dec_vec[3]),
        .insn_tdo (insn_tdo),
        .dr_tdo   (dr_tdo),
        .tdo      (tdo),
        .tdo_oe   (tdo_oe)
    );

    // Run of consecutive TMS=1 rising edges, saturating at TLR_TMS_ONES.
    localparam int ONES_W = $clog2(TLR_TMS_ONES + 1);
    logic [ONES_W-1:0] tms_ones_reg;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            tms_ones_reg <= '0;
        end else if (!tms) begin
            tms_ones_reg <= '0;
        end else if (tms_ones_reg != ONES_W'(TLR_TMS_ONES)) begin
            tms_ones_reg <= tms_ones_reg + 1'b1;
        end
    end

    a_tms_ones_reach_tlr : assert property (
        @(posedge tck) disable iff (!trstn)
        (tms_ones_reg == ONES_W'(TLR_TMS_ONES)) |-> (state_reg == TAP_TLR)
    );

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_jtag_tap_ctrl
// Randomised and directed TMS/data stimulus. A string-keyed state table taken
// from the IEEE 1149.1 transition rules predicts every cycle; predictions go
// into a queue and a separate monitor compares them against the DUT one cycle
// later. Reset behaviour is checked directly at the moments it must happen.
// ----------------------------------------------------------------------------
module tb_jtag_tap_ctrl;

    logic tck      = 1'b0;
    logic trstn    = 1'b1;
    logic tms      = 1'b1;
    logic insn_tdo = 1'b0;
    logic dr_tdo   = 1'b0;
    logic tdo, tdo_oe;
    logic s_tlr, s_rti, s_capdr, s_shdr, s_upddr, s_pausedr;
    logic s_capir, s_shir, s_updir, s_pauseir;
`ifdef JTAG_TAP_STATE_OUT_EN
    logic [3:0] tap_state;
`endif

    jtag_tap_ctrl dut (
        .tck                    (tck),
        .trstn                  (trstn),
        .tms                    (tms),
        .insn_tdo               (insn_tdo),
        .dr_tdo                 (dr_tdo),
        .tdo                    (tdo),
        .tdo_oe                 (tdo_oe),
        .state_test_logic_reset (s_tlr),
        .state_run_test_idle    (s_rti),
        .state_capture_dr       (s_capdr),
        .state_shift_dr         (s_shdr),
        .state_update_dr        (s_upddr),
        .state_pause_dr         (s_pausedr),
        .state_capture_ir       (s_capir),
        .state_shift_ir         (s_shir),
        .state_update_ir        (s_updir),
        .state_pause_ir         (s_pauseir)
`ifdef JTAG_TAP_STATE_OUT_EN
        ,
        .tap_state              (tap_state)
`endif
    );

    always #5 tck = ~tck;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    string nxt0 [string];
    string nxt1 [string];
    string all_states [16] = '{"TLR", "RTI", "SelDR", "CapDR", "ShDR", "Ex1DR",
                               "PauseDR", "Ex2DR", "UpdDR", "SelIR", "CapIR",
                               "ShIR", "Ex1IR", "PauseIR", "Ex2IR", "UpdIR"};
    string dec_names [10] = '{"TLR", "RTI", "CapDR", "ShDR", "UpdDR", "PauseDR",
                              "CapIR", "ShIR", "UpdIR", "PauseIR"};
`ifdef JTAG_TAP_STATE_OUT_EN
    int enc [string];
`endif

    string m_st  = "TLR";
    logic  m_tdo = 1'b0;
    logic  m_oe  = 1'b0;
    int    step_id = 0;

    typedef struct {
        string st;
        logic  tdo;
        logic  oe;
        int    id;
    } exp_t;
    exp_t exp_q [$];
    bit   path_q [$];

    logic [9:0] act_dec;
    assign act_dec = {s_tlr, s_rti, s_capdr, s_shdr, s_upddr, s_pausedr,
                      s_capir, s_shir, s_updir, s_pauseir};

    function automatic void add_rule(string s, string on0, string on1);
        nxt0[s] = on0;
        nxt1[s] = on1;
    endfunction

    function automatic void init_model();
        add_rule("TLR", "RTI", "TLR");
        add_rule("RTI", "RTI", "SelDR");
        add_rule("SelDR", "CapDR", "SelIR");
        add_rule("CapDR", "ShDR", "Ex1DR");
        add_rule("ShDR", "ShDR", "Ex1DR");
        add_rule("Ex1DR", "PauseDR", "UpdDR");
        add_rule("PauseDR", "PauseDR", "Ex2DR");
        add_rule("Ex2DR", "ShDR", "UpdDR");
        add_rule("UpdDR", "RTI", "SelDR");
        add_rule("SelIR", "CapIR", "TLR");
        add_rule("CapIR", "ShIR", "Ex1IR");
        add_rule("ShIR", "ShIR", "Ex1IR");
        add_rule("Ex1IR", "PauseIR", "UpdIR");
        add_rule("PauseIR", "PauseIR", "Ex2IR");
        add_rule("Ex2IR", "ShIR", "UpdIR");
        add_rule("UpdIR", "RTI", "SelDR");
`ifdef JTAG_TAP_STATE_OUT_EN
        enc["TLR"] = 15;   enc["RTI"] = 12;   enc["SelDR"] = 7;  enc["CapDR"] = 6;
        enc["ShDR"] = 2;   enc["Ex1DR"] = 1;  enc["PauseDR"] = 3; enc["Ex2DR"] = 0;
        enc["UpdDR"] = 5;  enc["SelIR"] = 4;  enc["CapIR"] = 14; enc["ShIR"] = 10;
        enc["Ex1IR"] = 9;  enc["PauseIR"] = 11; enc["Ex2IR"] = 8; enc["UpdIR"] = 13;
`endif
    endfunction

    function automatic logic [9:0] expect_dec(string s);
        logic [9:0] v = '0;
        for (int i = 0; i < 10; i++) begin
            if (dec_names[i] == s) v[9-i] = 1'b1;
        end
        return v;
    endfunction

    // Breadth-first search over the rule table for a TMS sequence from -> to.
    function automatic void find_path(string from, string to);
        string par [string];
        bit    ptms [string];
        string work [$];
        string cur;
        path_q.delete();
        par[from] = "";
        work.push_back(from);
        while (work.size() > 0) begin
            cur = work.pop_front();
            if (cur == to) break;
            for (int b = 0; b < 2; b++) begin
                string n = (b != 0) ? nxt1[cur] : nxt0[cur];
                if (!par.exists(n)) begin
                    par[n]  = cur;
                    ptms[n] = (b != 0);
                    work.push_back(n);
                end
            end
        end
        cur = to;
        while (cur != from) begin
            path_q.push_front(ptms[cur]);
            cur = par[cur];
        end
    endfunction

    function automatic bit rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    // ---------------- checking ----------------
    function automatic void check(string name, int actual, int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endfunction

    task automatic check_dut(string tag, string st, logic etdo, logic eoe);
        check({tag, " decodes(", st, ")"}, int'(act_dec), int'(expect_dec(st)));
        check({tag, " tdo"}, int'(tdo), int'(etdo));
        check({tag, " tdo_oe"}, int'(tdo_oe), int'(eoe));
`ifdef JTAG_TAP_STATE_OUT_EN
        check({tag, " tap_state"}, int'(tap_state), enc[st]);
`endif
    endtask

    // Monitor: one cycle after each stimulus step the DUT presents its new
    // state and the TDO value retimed on the preceding falling edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge tck);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("step %0d: expect %s tdo=%b oe=%b | dut dec=%h tdo=%b oe=%b",
                         e.id, e.st, e.tdo, e.oe, act_dec, tdo, tdo_oe);
                check_dut($sformatf("step%0d", e.id), e.st, e.tdo, e.oe);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called 2 time units after a rising edge. Data bits are sampled by the
    // DUT on the coming falling edge (current state), TMS on the next rising.
    task automatic step(input bit t, input bit it, input bit dt);
        exp_t e;
        tms      = t;
        insn_tdo = it;
        dr_tdo   = dt;
        if (m_st == "ShIR") begin
            m_tdo = it;
            m_oe  = 1'b1;
        end else if (m_st == "ShDR") begin
            m_tdo = dt;
            m_oe  = 1'b1;
        end else begin
            m_oe = 1'b0;
        end
        m_st = t ? nxt1[m_st] : nxt0[m_st];
        e.st  = m_st;
        e.tdo = m_tdo;
        e.oe  = m_oe;
        e.id  = step_id++;
        exp_q.push_back(e);
        @(posedge tck);
        #2;
    endtask

    // Assert trstn, check the immediate effect, hold two cycles, then release
    // one time unit ahead of a rising edge so that edge is the first to see
    // trstn high; the FSM must still sit in TLR after it.
    task automatic reset_pulse(input string tag);
        trstn = 1'b0;
        tms   = 1'b0;
        #1;
        m_st  = "TLR";
        m_tdo = 1'b0;
        m_oe  = 1'b0;
        check_dut({tag, " async"}, "TLR", 1'b0, 1'b0);
        repeat (2) @(posedge tck);
        #1;
        check_dut({tag, " held"}, "TLR", 1'b0, 1'b0);
        @(negedge tck);
        #4;
        trstn = 1'b1;
        @(posedge tck);
        #1;
        check_dut({tag, " release edge"}, "TLR", 1'b0, 1'b0);
        #1;
    endtask

    bit seq_ir [5]  = '{0, 1, 1, 0, 0};
    bit ir_bits [4] = '{1, 0, 1, 0};
    bit dr_seq [13] = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0};

    initial begin
        init_model();
        #1;
        reset_pulse("por");

        // IR column: TLR -> RTI -> SelDR -> SelIR -> CapIR -> ShIR
        foreach (seq_ir[i]) step(seq_ir[i], rb(), rb());
        foreach (ir_bits[i]) step(1'b0, ir_bits[i], rb());
        step(1'b1, rb(), rb());     // -> Ex1IR (last shifted bit)
        step(1'b1, rb(), rb());     // -> UpdIR
        step(1'b0, rb(), rb());     // -> RTI

        // DR column with dr_tdo held high
        foreach (dr_seq[i]) step(dr_seq[i], rb(), 1'b1);

        // Reset in the middle of Shift-DR, then first transition after release
        step(1'b1, rb(), 1'b1);
        step(1'b0, rb(), 1'b1);
        step(1'b0, rb(), 1'b1);
        step(1'b0, rb(), 1'b1);
        reset_pulse("mid_shdr");
        step(1'b0, rb(), rb());     // first edge after release: TLR -> RTI

        // From every state, five TMS=1 edges reach TLR and further ones hold it
        foreach (all_states[k]) begin
            find_path(m_st, all_states[k]);
            foreach (path_q[j]) step(path_q[j], rb(), rb());
            repeat (5) step(1'b1, rb(), rb());
            repeat (2) step(1'b1, rb(), rb());
        end

        // Random walk with occasional resets
        repeat (400) begin
            if ($urandom_range(0, 99) == 0) reset_pulse("rand");
            else step(($urandom_range(0, 2) == 0), rb(), rb());
        end

        repeat (2) @(posedge tck);
        #3;
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
